// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with busy scoreboard and sequential clear engine
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              busy0,
  output logic              busy1
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                zero_en;
  logic                bypass_en;
  logic                write_ok;
  logic                iss_ok;
  logic                hit0;
  logic                hit1;

  assign zero_en   = (ZERO_REG != 0);
  assign bypass_en = (BYPASS != 0);

  // A clear request in IDLE preempts any write or issue in the same cycle.
  assign write_ok = ready_q && we && !clr_req && !(zero_en && (waddr == '0));
  assign iss_ok   = ready_q && iss_valid && !clr_req && !(zero_en && (iss_rd == '0));

  assign hit0 = bypass_en && write_ok && (waddr == raddr0);
  assign hit1 = bypass_en && write_ok && (waddr == raddr1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      ready_q   <= 1'b0;
      clr_cnt_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          ready_d   = 1'b0;
          clr_cnt_d = '0;
          busy_d    = '0;
        end else begin
          // Clear first so that a same-cycle issue to the same entry wins.
          if (write_ok) busy_d[waddr] = 1'b0;
          if (iss_ok)   busy_d[iss_rd] = 1'b1;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        ready_d   = 1'b0;
        clr_cnt_d = '0;
        busy_d    = '0;
      end
    endcase
  end

  // Array has no reset; the clear engine owns initialisation.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (write_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata0 = '0;
    busy0  = 1'b0;
    if (ready_q) begin
      if (hit0) begin
        rdata0 = wdata;
      end else if (!(zero_en && (raddr0 == '0))) begin
        rdata0 = mem[raddr0];
        busy0  = busy_q[raddr0];
      end
    end
  end

  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (ready_q) begin
      if (hit1) begin
        rdata1 = wdata;
      end else if (!(zero_en && (raddr1 == '0))) begin
        rdata1 = mem[raddr1];
        busy1  = busy_q[raddr1];
      end
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed self-checking bench for regfile_param
module tb_regfile_param;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr0;
  logic [31:0] rdata0;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        busy0;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  regfile_param dut (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .ready     (ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .raddr0    (raddr0),
    .rdata0    (rdata0),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy0     (busy0),
    .busy1     (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr_req = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr0 = '0; raddr1 = '0; iss_valid = 1'b0; iss_rd = '0;

    // reset state
    step(); step();
    raddr0 = 5'd5; raddr1 = 5'd6;
    #1;
    check("rst_ready", ready, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_busy0", busy0, 0);

    // clear after reset release: ready rises on the 32nd edge
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("clr_ready_%0d", i), ready, (i == 32) ? 1 : 0);
    end
    for (int k = 0; k < 32; k++) begin
      raddr0 = k[4:0]; raddr1 = 5'(31 - k);
      #1;
      check($sformatf("post_clr_rd0_%0d", k), rdata0, 0);
      check($sformatf("post_clr_rd1_%0d", k), rdata1, 0);
    end

    // writes, zero register
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; step();
    waddr = 5'd0; wdata = 32'h00001234; raddr0 = 5'd0;
    #1;
    check("zero_no_bypass", rdata0, 0);
    step();
    we = 1'b0; raddr0 = 5'd5; raddr1 = 5'd0;
    #1;
    check("rd_5", rdata0, 32'hDEADBEEF);
    check("rd_zero", rdata1, 0);

    // bypass into an entry still holding 0
    raddr0 = 5'd7; raddr1 = 5'd7;
    #1;
    check("pre_bypass", rdata0, 0);
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1;
    check("bypass_rd0", rdata0, 32'hA5A5A5A5);
    check("bypass_rd1", rdata1, 32'hA5A5A5A5);
    step();
    we = 1'b0;
    #1;
    check("after_bypass", rdata0, 32'hA5A5A5A5);

    // scoreboard
    iss_valid = 1'b1; iss_rd = 5'd3; step();
    iss_valid = 1'b0; raddr0 = 5'd3; raddr1 = 5'd3;
    #1;
    check("busy_set", busy0, 1);
    we = 1'b1; waddr = 5'd3; wdata = 32'h33; iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    check("busy_hidden0", busy0, 0);
    check("busy_hidden1", busy1, 0);
    check("wb_bypass", rdata0, 32'h33);
    step();
    we = 1'b0; iss_valid = 1'b0;
    #1;
    check("set_wins", busy0, 1);
    we = 1'b1; wdata = 32'h44; step();
    we = 1'b0;
    #1;
    check("busy_cleared", busy0, 0);
    check("busy_cleared_rd", rdata1, 32'h44);
    iss_valid = 1'b1; iss_rd = 5'd0; step();
    iss_valid = 1'b0; raddr0 = 5'd0;
    #1;
    check("zero_issue_ignored", busy0, 0);

    // clr_req preempts a write
    for (int k = 1; k <= 4; k++) begin
      we = 1'b1; waddr = k[4:0]; wdata = 32'h11 * k; step();
    end
    we = 1'b0; iss_valid = 1'b1; iss_rd = 5'd2; step();
    iss_valid = 1'b0; raddr0 = 5'd1; raddr1 = 5'd2;
    #1;
    check("pre_clr_rd1", rdata0, 32'h11);
    check("pre_clr_busy2", busy1, 1);
    clr_req = 1'b1; we = 1'b1; waddr = 5'd1; wdata = 32'hFFFFFFFF;
    #1;
    check("clr_drop_bypass", rdata0, 32'h11);
    step();
    we = 1'b0;
    #1;
    check("clr_ready_low", ready, 0);
    // clr_req held for the first few clear cycles must not restart it
    for (int i = 1; i <= 32; i++) begin
      step();
      clr_req = (i < 5);
      check($sformatf("req_clr_ready_%0d", i), ready, (i == 32) ? 1 : 0);
    end
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      raddr0 = k[4:0]; raddr1 = k[4:0];
      #1;
      check($sformatf("req_clr_rd_%0d", k), rdata0, 0);
      check($sformatf("req_clr_busy_%0d", k), busy1, 0);
    end

    // reset in the middle of a clear
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; step();
    we = 1'b0; clr_req = 1'b1; step();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", ready, 0);
    step(); step();
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("rst_clr_ready_%0d", i), ready, (i == 32) ? 1 : 0);
    end
    raddr0 = 5'd9; raddr1 = 5'd31;
    #1;
    check("rst_clr_rd9", rdata0, 0);
    check("rst_clr_rd31", rdata1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
